inst_fetch_unit: RTL and testbench

- Instruction fetch front end; produces the 32-bit instruction word and its PC consumed by the control decoder.
- Consumes the decoder's PC-select result (redirect) and the branch/jump target.
- Talks to instruction memory over a req/ack + rvalid protocol with at most one outstanding request.
- Buffers fetched words in a small FIFO toward the decode stage, using a valid/ready handshake.

---
 rtl/inst_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: single-outstanding imem request engine feeding
// a small instruction FIFO toward the decoder, with redirect/flush handling.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Inst,
    output logic [31:0] inst_pc
);

    localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_RESP,
        S_DISCARD
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        fifo_inst_q [DEPTH];
    logic [31:0]        fifo_pc_q   [DEPTH];

    logic               has_room;
    logic               push;
    logic               pop;

    assign has_room   = (count_q < CNT_W'(DEPTH));
    assign inst_valid = (count_q != '0);
    assign Inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : NOP;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;
    assign imem_req   = (state_q == S_WAIT_ACK);
    assign imem_addr  = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!redirect && has_room) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // An ack landing with a redirect still owes us one response to swallow.
                if (redirect) begin
                    state_d = imem_ack ? S_DISCARD : S_IDLE;
                end else if (imem_ack) begin
                    state_d    = S_WAIT_RESP;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_WAIT_RESP: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                    push    = !redirect;
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    always_comb begin
        pop      = inst_valid && inst_ready && !redirect;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: memory model plus queues of expected
// request addresses and expected decoded (pc, word) pairs.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] Inst;
    logic [31:0] inst_pc;

    logic        auto_mem;
    logic        man_ack, man_rv;
    logic [31:0] man_rdata;
    logic        auto_rv;
    logic [31:0] auto_rdata;
    logic        hs_pend;
    logic [31:0] hs_addr;

    int n_chk  = 0;
    int n_pass = 0;
    int pop_cnt = 0;
    int hs_cnt  = 0;

    logic [31:0] exp_req [$];
    logic [31:0] exp_out [$];

    always #5 clk = ~clk;

    assign imem_ack    = auto_mem ? imem_req   : man_ack;
    assign imem_rvalid = auto_mem ? auto_rv    : man_rv;
    assign imem_rdata  = auto_mem ? auto_rdata : man_rdata;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .Inst(Inst), .inst_pc(inst_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(pop_cnt >= target), 32'd1);
    endtask

    task automatic do_reset(input logic auto_mode);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        man_ack = 1'b0; man_rv = 1'b0; man_rdata = '0; auto_mem = auto_mode;
        tick();
        tick();
        exp_req.delete();
        exp_out.delete();
    endtask

    // Memory model (auto mode): ack with req, rvalid exactly one cycle later.
    // Monitors: accepted request address and every decoder pop.
    always @(negedge clk) begin
        logic [31:0] e;
        if (imem_req && imem_ack) begin
            hs_cnt++;
            hs_pend = 1'b1;
            hs_addr = imem_addr;
            if (exp_req.size() > 0) check_val("req_addr", imem_addr, exp_req.pop_front());
        end else begin
            hs_pend = 1'b0;
        end
        if (inst_valid && inst_ready) begin
            pop_cnt++;
            if (exp_out.size() > 0) begin
                e = exp_out.pop_front();
                check_val("inst_pc", inst_pc, e);
                check_val("inst_word", Inst, mem_word(e));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        auto_rv    = hs_pend;
        auto_rdata = mem_word(hs_addr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, h0;
        hs_pend = 1'b0; hs_addr = '0; auto_rv = 1'b0; auto_rdata = '0;

        // Reset values
        do_reset(1'b1);
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_valid", 32'(inst_valid), 32'd0);
        check_val("rst_inst", Inst, 32'h0000_0013);
        check_val("rst_pc", inst_pc, 32'h0);

        // Streaming with zero-wait memory
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_out = '{32'h0, 32'h4, 32'h8};
        inst_ready = 1'b1;
        p0 = pop_cnt;
        rst = 1'b0;
        wait_pops(p0 + 1, 20, "stream_first");
        wait_pops(p0 + 2, 3, "stream_gap1");
        wait_pops(p0 + 3, 3, "stream_gap2");
        check_val("stream_req_drained", 32'(exp_req.size()), 32'd0);

        // Decoder stall fills the FIFO exactly
        do_reset(1'b1);
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_out = '{32'h0, 32'h4, 32'h8};
        h0 = hs_cnt;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_val("stall_hs", 32'(hs_cnt - h0), 32'd2);
        check_val("stall_req", 32'(imem_req), 32'd0);
        check_val("stall_valid", 32'(inst_valid), 32'd1);
        check_val("stall_head_pc", inst_pc, 32'h0);
        p0 = pop_cnt;
        inst_ready = 1'b1;
        wait_pops(p0 + 3, 20, "stall_resume");

        // Redirect in WAIT_ACK (no ack), then in WAIT_RESP with a late rvalid
        do_reset(1'b0);
        inst_ready = 1'b1;
        rst = 1'b0;
        tick();
        check_val("wa_req", 32'(imem_req), 32'd1);
        check_val("wa_addr", imem_addr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h0000_0010;
        tick();
        redirect = 1'b0;
        check_val("wa_drop_req", 32'(imem_req), 32'd0);
        tick();
        check_val("wa_re_req", 32'(imem_req), 32'd1);
        check_val("wa_re_addr", imem_addr, 32'h10);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check_val("wr_flush_valid", 32'(inst_valid), 32'd0);
        man_rv = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        man_rv = 1'b0;
        check_val("wr_dropped", 32'(inst_valid), 32'd0);
        exp_req.push_back(32'h100);
        exp_out.push_back(32'h100);
        tick();
        check_val("wr_new_addr", imem_addr, 32'h100);
        check_val("wr_new_req", 32'(imem_req), 32'd1);
        p0 = pop_cnt;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0; man_rv = 1'b1; man_rdata = mem_word(32'h100);
        tick();
        man_rv = 1'b0;
        wait_pops(p0 + 1, 4, "wr_pop");

        // Redirect coinciding with ack -> DISCARD, then a second redirect
        do_reset(1'b0);
        inst_ready = 1'b1;
        rst = 1'b0;
        tick();
        check_val("dc_req", 32'(imem_req), 32'd1);
        man_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        man_ack = 1'b0; redirect = 1'b0;
        check_val("dc_req_off", 32'(imem_req), 32'd0);
        tick();
        check_val("dc_hold", 32'(imem_req), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check_val("dc2_addr", imem_addr, 32'h200);
        man_rv = 1'b1; man_rdata = 32'hBAD0_0100;
        tick();
        man_rv = 1'b0;
        check_val("dc_swallow", 32'(inst_valid), 32'd0);
        exp_req.push_back(32'h200);
        exp_out.push_back(32'h200);
        tick();
        check_val("dc_next_req", 32'(imem_req), 32'd1);
        check_val("dc_next_addr", imem_addr, 32'h200);
        p0 = pop_cnt;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0; man_rv = 1'b1; man_rdata = mem_word(32'h200);
        tick();
        man_rv = 1'b0;
        wait_pops(p0 + 1, 4, "dc_pop");

        // Address wrap at the top of memory
        do_reset(1'b1);
        inst_ready = 1'b1;
        exp_req = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_out = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        p0 = pop_cnt;
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check_val("wrap_align", imem_addr, 32'hFFFF_FFFC);
        check_val("wrap_idle", 32'(imem_req), 32'd0);
        wait_pops(p0 + 3, 30, "wrap_pops");

        // Reset in the middle of WAIT_RESP with a buffered entry
        do_reset(1'b0);
        rst = 1'b0;
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0; man_rv = 1'b1; man_rdata = 32'h1234_5678;
        tick();
        man_rv = 1'b0;
        tick();
        check_val("mr_valid", 32'(inst_valid), 32'd1);
        check_val("mr_addr4", imem_addr, 32'h4);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        rst = 1'b1;
        tick();
        check_val("mr_req", 32'(imem_req), 32'd0);
        check_val("mr_valid0", 32'(inst_valid), 32'd0);
        check_val("mr_nop", Inst, 32'h0000_0013);
        check_val("mr_pc0", inst_pc, 32'h0);
        rst = 1'b0;
        tick();
        check_val("mr_refetch_req", 32'(imem_req), 32'd1);
        check_val("mr_refetch_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
